seq_match_fsm: RTL

Parametrised sequence-match state machine, successor to the fixed 8-step X==Y matcher.
- Compares two WIDTH-bit operands once per STEP strobe.
- Counts consecutive matches toward LENGTH, with a checkpoint and fallback on late mismatches.
- Holds a completion flag for HOLD_CYCLES clocks; this synthesisable timer replaces the simulation-only delay.
- Sits between the input-capture logic and the game/score controller in the PBP design.

---
 rtl/seq_match_pkg.sv | 24 ++
 rtl/seq_match_fsm_hold_timer.sv | 30 +++
 rtl/seq_match_fsm.sv | 124 ++++++++++++
 3 files changed

// File: rtl/seq_match_pkg.sv
// Shared types, defaults and width helpers for the seq_match_fsm sequence matcher.
package seq_match_pkg;

    typedef enum logic [0:0] {
        ST_TRACK = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    localparam int unsigned DEF_WIDTH       = 1;
    localparam int unsigned DEF_LENGTH      = 8;
    localparam int unsigned DEF_CHECKPOINT  = 5;
    localparam int unsigned DEF_FALLBACK    = 1;
    localparam int unsigned DEF_HOLD_CYCLES = 100;

    function automatic int unsigned prog_width(input int unsigned len);
        return $clog2(len + 1);
    endfunction

    // A single-cycle hold still needs a one-bit counter to exist.
    function automatic int unsigned hold_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/seq_match_fsm_hold_timer.sv
// Loadable down-counter that times the completion hold period of seq_match_fsm.
module hold_timer
    import seq_match_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned CW          = hold_width(HOLD_CYCLES)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_zero
);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/seq_match_fsm.sv
// Parametrised consecutive-match tracker with checkpoint fallback and a timed completion flag.
// Optional build macro SEQ_MATCH_MASK_EN adds a MASK input marking don't-care operand bits.
module seq_match_fsm
    import seq_match_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned LENGTH      = DEF_LENGTH,
    parameter int unsigned CHECKPOINT  = DEF_CHECKPOINT,
    parameter int unsigned FALLBACK    = DEF_FALLBACK,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          STEP,
    input  logic [WIDTH-1:0]              X,
    input  logic [WIDTH-1:0]              Y,
`ifdef SEQ_MATCH_MASK_EN
    input  logic [WIDTH-1:0]              MASK,
`endif
    output logic                          Z,
    output logic                          MISS,
    output logic [prog_width(LENGTH)-1:0] PROGRESS,
    output logic                          BUSY
);

    localparam int unsigned PW = prog_width(LENGTH);
    localparam int unsigned CW = hold_width(HOLD_CYCLES);

    if (LENGTH < 2) begin : g_bad_length
        $error("seq_match_fsm: LENGTH must be >= 2");
    end
    if ((CHECKPOINT > LENGTH - 1) || (FALLBACK > CHECKPOINT)) begin : g_bad_checkpoint
        $error("seq_match_fsm: need FALLBACK <= CHECKPOINT <= LENGTH-1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("seq_match_fsm: HOLD_CYCLES must be >= 1");
    end

    state_e        r_state;
    logic [PW-1:0] r_progress;
    logic          r_z;
    logic          r_miss;
    logic          r_busy;

    logic w_match;
    logic w_last;
    logic w_load;
    logic w_hold_zero;

`ifdef SEQ_MATCH_MASK_EN
    assign w_match = (((X ^ Y) & ~MASK) == '0);
`else
    assign w_match = (X == Y);
`endif

    assign w_last = (r_progress == PW'(LENGTH - 1));
    assign w_load = (r_state == ST_TRACK) && STEP && w_match && w_last;

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CW          (CW)
    ) u_hold_timer (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_load     (w_load),
        .i_load_val (CW'(HOLD_CYCLES - 1)),
        .i_dec      (r_state == ST_HOLD),
        .o_zero     (w_hold_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_TRACK;
            r_progress <= '0;
            r_z        <= 1'b0;
            r_miss     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            unique case (r_state)
                ST_TRACK: begin
                    r_miss <= 1'b0;
                    if (STEP) begin
                        if (w_match) begin
                            if (w_last) begin
                                r_state    <= ST_HOLD;
                                r_progress <= PW'(LENGTH);
                                r_z        <= 1'b1;
                                r_busy     <= 1'b1;
                            end else begin
                                r_progress <= r_progress + 1'b1;
                            end
                        end else begin
                            r_miss     <= 1'b1;
                            r_progress <= (r_progress >= PW'(CHECKPOINT)) ? PW'(FALLBACK) : '0;
                        end
                    end
                end
                ST_HOLD: begin
                    // Operands are ignored here, including on the exit clock.
                    r_miss <= 1'b0;
                    if (w_hold_zero) begin
                        r_state    <= ST_TRACK;
                        r_progress <= '0;
                        r_z        <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_TRACK;
                    r_progress <= '0;
                    r_z        <= 1'b0;
                    r_miss     <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign Z        = r_z;
    assign MISS     = r_miss;
    assign PROGRESS = r_progress;
    assign BUSY     = r_busy;

endmodule
